// File: rtl/word_matcher.sv
// rtl/word_matcher.sv - vocabulary table with linear-scan word lookup
// Optional MATCHER_CASE_FOLD_EN: ASCII case-insensitive compare (DATA_WIDTH==8 only).
module word_matcher #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8,
  localparam int W          = WORD_LENGTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [W-1:0]          wr_data,
  input  logic                  start,
  input  logic [W-1:0]          word,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic [ADDR_WIDTH-1:0] curr_vocab_addr,
  output logic                  vocab_overflow,
  output logic                  nullptr_vocab
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_next;
  logic [W-1:0]   vocab [2**ADDR_WIDTH];
  logic [W-1:0]   search_word;
  logic [W-1:0]   curr_vocab;
  logic           accept;
  logic           hit_null, hit_match, hit_end, advance;

  function automatic logic [W-1:0] fold(input logic [W-1:0] w);
    logic [W-1:0]          r;
    logic [DATA_WIDTH-1:0] c;
    r = w;
`ifdef MATCHER_CASE_FOLD_EN
    for (int i = 0; i < WORD_LENGTH; i++) begin
      c = w[i*DATA_WIDTH +: DATA_WIDTH];
      if (DATA_WIDTH == 8 && c >= DATA_WIDTH'(8'h41) && c <= DATA_WIDTH'(8'h5A))
        r[i*DATA_WIDTH +: DATA_WIDTH] = c + DATA_WIDTH'(8'h20);
    end
`else
    c = '0;
`endif
    return r;
  endfunction

  assign curr_vocab = vocab[curr_vocab_addr];
  assign busy       = (state == SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Priority: empty entry, then match, then end of table.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit_null   = 1'b0;
    hit_match  = 1'b0;
    hit_end    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (curr_vocab == '0) begin
          hit_null   = 1'b1;
          state_next = IDLE;
        end else if (fold(curr_vocab) == fold(search_word)) begin
          hit_match  = 1'b1;
          state_next = IDLE;
        end else if (curr_vocab_addr == '1) begin
          hit_end    = 1'b1;
          state_next = IDLE;
        end else begin
          advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) vocab[i] <= '0;
      search_word     <= '0;
      done            <= 1'b0;
      found           <= 1'b0;
      match_addr      <= '0;
      curr_vocab_addr <= '0;
      vocab_overflow  <= 1'b0;
      nullptr_vocab   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && wr_en) vocab[wr_addr] <= wr_data;
      if (accept) begin
        search_word     <= word;
        found           <= 1'b0;
        match_addr      <= '0;
        curr_vocab_addr <= '0;
        vocab_overflow  <= 1'b0;
        nullptr_vocab   <= 1'b0;
      end
      if (hit_null) begin
        nullptr_vocab <= 1'b1;
        done          <= 1'b1;
      end
      if (hit_match) begin
        found      <= 1'b1;
        match_addr <= curr_vocab_addr;
        done       <= 1'b1;
      end
      if (hit_end) begin
        vocab_overflow <= 1'b1;
        done           <= 1'b1;
      end
      if (advance) curr_vocab_addr <= curr_vocab_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_word_matcher.sv
// tb/tb_word_matcher.sv - scoreboard bench for word_matcher against a table-scan model
module tb_word_matcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic [23:0] word = '0;
  logic        busy, done, found, vocab_overflow, nullptr_vocab;
  logic [3:0]  match_addr, curr_vocab_addr;

  word_matcher dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .word(word), .busy(busy), .done(done), .found(found),
    .match_addr(match_addr), .curr_vocab_addr(curr_vocab_addr),
    .vocab_overflow(vocab_overflow), .nullptr_vocab(nullptr_vocab)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic [3:0] a;
    logic       o;
    logic       n;
    logic [3:0] c;
    int         dc;
  } exp_t;

  exp_t        q[$];
  logic [23:0] tab [16];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] lower(input logic [23:0] w);
    logic [23:0] r;
    r = w;
`ifdef MATCHER_CASE_FOLD_EN
    for (int i = 0; i < 3; i++)
      if (w[i*8 +: 8] >= "A" && w[i*8 +: 8] <= "Z") r[i*8 +: 8] = w[i*8 +: 8] + 8'd32;
`endif
    return r;
  endfunction

  // Scan the model table from 0: empty entry ends vocabulary, else match, else overflow.
  function automatic exp_t model_lookup(input logic [23:0] w, input int sc);
    exp_t e;
    e.f = 0; e.a = 0; e.o = 1; e.n = 0; e.c = 4'd15; e.dc = sc + 17;
    for (int i = 0; i < 16; i++) begin
      if (tab[i] == 24'd0) begin
        e.o = 0; e.n = 1; e.c = 4'(i); e.dc = sc + i + 2;
        return e;
      end
      if (lower(tab[i]) == lower(w)) begin
        e.o = 0; e.f = 1; e.a = 4'(i); e.c = 4'(i); e.dc = sc + i + 2;
        return e;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending lookup (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle", cyc, e.dc);
        check("found", found, e.f);
        check("match_addr", match_addr, e.a);
        check("vocab_overflow", vocab_overflow, e.o);
        check("nullptr_vocab", nullptr_vocab, e.n);
        check("curr_vocab_addr", curr_vocab_addr, e.c);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic write_entry(input logic [3:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = a; wr_data = d; tab[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic lookup(input logic [23:0] w, input bit wr, input logic [3:0] wa,
                        input logic [23:0] wd, input bit poke);
    @(negedge clk);
    if (wr) begin
      wr_en = 1; wr_addr = wa; wr_data = wd; tab[wa] = wd;
    end
    q.push_back(model_lookup(w, cyc));
    start = 1; word = w;
    @(negedge clk);
    start = 0; wr_en = 0; word = 24'($urandom);
    check("busy_after_start", busy, 1);
    if (poke) begin
      @(negedge clk);
      wr_en = 1; wr_addr = 0; wr_data = w; start = 1; word = w;
      @(negedge clk);
      wr_en = 0; start = 0;
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d pending lookups expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    c = 8'h61 + 8'($urandom_range(0, 4));
    if ($urandom_range(0, 1) == 1) c = c - 8'h20;
    return c;
  endfunction

  function automatic logic [23:0] rand_word();
    return {rand_char(), rand_char(), rand_char()};
  endfunction

  initial begin
    logic [23:0] w, s;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_match_addr", match_addr, 0);
    check("rst_curr_addr", curr_vocab_addr, 0);
    check("rst_overflow", vocab_overflow, 0);
    check("rst_nullptr", nullptr_vocab, 0);

    write_entry(0, "abc");
    write_entry(1, "xyz");
    write_entry(2, "Hel");
    lookup(24'h48656C, 0, 0, 0, 0);
    lookup("Hez", 0, 0, 0, 0);

    for (int i = 3; i < 16; i++) write_entry(4'(i), {3{8'h61 + 8'(i)}});
    lookup("qqq", 0, 0, 0, 0);
    lookup("qqq", 0, 0, 0, 1);
    lookup("zzz", 1, 4'd15, "zzz", 0);

    // Abort a long scan with reset: no done pulse may appear, table must clear.
    @(negedge clk);
    start = 1; word = "rrr";
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_found", found, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    lookup("abc", 0, 0, 0, 0);

    write_entry(0, "hel");
    lookup("HEL", 0, 0, 0, 0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        write_entry(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0) ? 24'd0 : rand_word());
      s = tab[$urandom_range(0, 15)];
      w = s;
      for (int k = 0; k < 3; k++)
        if (s[k*8 +: 8] != 0 && $urandom_range(0, 1) == 1) w[k*8 +: 8] = s[k*8 +: 8] ^ 8'h20;
      if ($urandom_range(0, 1) == 1) w = rand_word();
      if ($urandom_range(0, 15) == 0) w = 24'd0;
      if ($urandom_range(0, 3) == 0)
        lookup(w, 1, 4'($urandom_range(0, 15)), rand_word(), 0);
      else
        lookup(w, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
